// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: instruction fetch stage feeding decode.
//   Owns the PC, issues word requests to instruction memory (req/ack), holds
//   the fetched word in an instruction register presented to decode
//   (valid/ready), and applies branch redirects, discarding wrong-path data.
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   imem_req/imem_addr     memory request and word-aligned byte address
//   imem_rdata/imem_ack    returned instruction word and completion strobe
//   id_valid/id_ready      handshake to decode
//   id_instr/id_pc         instruction register and its PC
//   br_taken/br_target     redirect pulse and target byte address
//   misalign_err           sticky flag: misaligned redirect target seen
//   fetch_count            instructions accepted by decode (mod 2^32)
module rv_fetch_unit #(
  parameter int unsigned           XLEN     = 64,
  parameter logic [XLEN-1:0]       RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            misalign_err,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DRAIN,
    S_VALID,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic            id_valid_q, id_valid_d;
  logic            req_q, req_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     count_q, count_d;

  logic            br_misaligned;
  logic            ack_seen;

  assign br_misaligned = br_taken && (br_target[1:0] != 2'b00);
  // The request is registered so it reads 0 straight out of reset; an ack
  // only counts while the request is actually being driven.
  assign ack_seen      = req_q && imem_ack;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    id_pc_d       = id_pc_q;
    id_instr_d    = id_instr_q;
    id_valid_d    = id_valid_q;
    misalign_d    = misalign_q;
    count_d       = count_q;

    if (br_misaligned) begin
      misalign_d = 1'b1;
      id_valid_d = 1'b0;
      state_d    = S_ERR;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (br_taken) begin
            // An unfinished request must keep its address until acked.
            if (req_q && !imem_ack) begin
              pend_target_d = br_target;
              state_d       = S_DRAIN;
            end else begin
              pc_d = br_target;
            end
          end else if (ack_seen) begin
            id_instr_d = imem_rdata;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            state_d    = S_VALID;
          end
        end
        S_DRAIN: begin
          if (br_taken) pend_target_d = br_target;
          if (imem_ack) begin
            pc_d    = br_taken ? br_target : pend_target_q;
            state_d = S_FETCH;
          end
        end
        S_VALID: begin
          if (br_taken) begin
            id_valid_d = 1'b0;
            pc_d       = br_target;
            state_d    = S_FETCH;
          end else if (id_ready) begin
            count_d    = count_q + 32'd1;
            pc_d       = pc_q + XLEN'(4);
            id_valid_d = 1'b0;
            state_d    = S_FETCH;
          end
        end
        default: ;
      endcase
    end

    req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      id_pc_q       <= '0;
      id_instr_q    <= '0;
      id_valid_q    <= 1'b0;
      req_q         <= 1'b0;
      misalign_q    <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      id_pc_q       <= id_pc_d;
      id_instr_q    <= id_instr_d;
      id_valid_q    <= id_valid_d;
      req_q         <= req_d;
      misalign_q    <= misalign_d;
      count_q       <= count_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign id_valid     = id_valid_q;
  assign id_instr     = id_instr_q;
  assign id_pc        = id_pc_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
module tb_rv_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        id_ready;
  logic        br_taken;
  logic [63:0] br_target;

  logic        imem_req, id_valid, misalign_err;
  logic [63:0] imem_addr, id_pc;
  logic [31:0] id_instr, fetch_count;

  logic        w_req, w_valid, w_err;
  logic [63:0] w_addr, w_id_pc;
  logic [31:0] w_instr, w_count;

  int passed;
  int total;

  rv_fetch_unit #(.XLEN(64), .RESET_PC(64'h1000)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc),
    .br_taken(br_taken), .br_target(br_target),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  rv_fetch_unit #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .id_valid(w_valid), .id_ready(id_ready),
    .id_instr(w_instr), .id_pc(w_id_pc),
    .br_taken(br_taken), .br_target(br_target),
    .misalign_err(w_err), .fetch_count(w_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", id_valid); else passed++;
    total++; if (imem_addr !== 64'h1000) $display("FAIL reset_addr got=%h exp=1000", imem_addr); else passed++;
    total++; if (id_pc !== 64'h0) $display("FAIL reset_id_pc got=%h exp=0", id_pc); else passed++;
    total++; if (id_instr !== 32'h0) $display("FAIL reset_id_instr got=%h exp=0", id_instr); else passed++;
    total++; if (fetch_count !== 32'h0) $display("FAIL reset_count got=%0d exp=0", fetch_count); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", misalign_err); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait();
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000) $display("FAIL zw_req0 got req=%b addr=%h exp req=1 addr=1000", imem_req, imem_addr); else passed++;
    id_ready = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    total++; if (id_valid !== 1'b1 || id_pc !== 64'h1000 || id_instr !== 32'h0050_0093) $display("FAIL zw_out0 got v=%b pc=%h i=%h exp v=1 pc=1000 i=00500093", id_valid, id_pc, id_instr); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL zw_req_gap0 got=%b exp=0", imem_req); else passed++;
    imem_ack = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h1004 || id_valid !== 1'b0) $display("FAIL zw_req1 got req=%b addr=%h v=%b exp req=1 addr=1004 v=0", imem_req, imem_addr, id_valid); else passed++;
    total++; if (fetch_count !== 32'd1) $display("FAIL zw_count1 got=%0d exp=1", fetch_count); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    total++; if (id_valid !== 1'b1 || id_pc !== 64'h1004 || id_instr !== 32'h00A0_0113) $display("FAIL zw_out1 got v=%b pc=%h i=%h exp v=1 pc=1004 i=00a00113", id_valid, id_pc, id_instr); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL zw_req_gap1 got=%b exp=0", imem_req); else passed++;
    imem_ack = 1'b0;
    tick();
    total++; if (fetch_count !== 32'd2 || imem_addr !== 64'h1008 || imem_req !== 1'b1) $display("FAIL zw_count2 got cnt=%0d addr=%h req=%b exp cnt=2 addr=1008 req=1", fetch_count, imem_addr, imem_req); else passed++;
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (id_valid !== 1'b1 || id_pc !== 64'h1008 || id_instr !== 32'h1111_1111 || imem_req !== 1'b0 || fetch_count !== 32'd2)
        $display("FAIL bp_hold%0d got v=%b pc=%h i=%h req=%b cnt=%0d exp v=1 pc=1008 i=11111111 req=0 cnt=2", i, id_valid, id_pc, id_instr, imem_req, fetch_count);
      else passed++;
      tick();
    end
    id_ready = 1'b1;
    tick();
    total++; if (imem_addr !== 64'h100C || imem_req !== 1'b1 || fetch_count !== 32'd3) $display("FAIL bp_release got addr=%h req=%b cnt=%0d exp addr=100c req=1 cnt=3", imem_addr, imem_req, fetch_count); else passed++;
  endtask

  task automatic test_redirect_valid();
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    total++; if (id_valid !== 1'b1 || id_pc !== 64'h100C) $display("FAIL rv_pre got v=%b pc=%h exp v=1 pc=100c", id_valid, id_pc); else passed++;
    imem_ack = 1'b0; id_ready = 1'b1; br_taken = 1'b1; br_target = 64'h2000;
    tick();
    br_taken = 1'b0;
    total++; if (id_valid !== 1'b0 || fetch_count !== 32'd3) $display("FAIL rv_drop got v=%b cnt=%0d exp v=0 cnt=3", id_valid, fetch_count); else passed++;
    total++; if (imem_addr !== 64'h2000 || imem_req !== 1'b1) $display("FAIL rv_addr got addr=%h req=%b exp addr=2000 req=1", imem_addr, imem_req); else passed++;
  endtask

  task automatic test_redirect_fetch_ack();
    imem_ack = 1'b1; imem_rdata = 32'h3333_3333; br_taken = 1'b1; br_target = 64'h1008;
    tick();
    imem_ack = 1'b0; br_taken = 1'b0;
    total++; if (id_valid !== 1'b0 || imem_addr !== 64'h1008 || imem_req !== 1'b1) $display("FAIL rfa got v=%b addr=%h req=%b exp v=0 addr=1008 req=1", id_valid, imem_addr, imem_req); else passed++;
    total++; if (id_instr !== 32'h2222_2222) $display("FAIL rfa_instr got=%h exp=22222222", id_instr); else passed++;
  endtask

  task automatic test_redirect_midtxn();
    br_taken = 1'b1; br_target = 64'h3000;
    tick();
    br_taken = 1'b0;
    total++; if (imem_addr !== 64'h1008 || imem_req !== 1'b1) $display("FAIL mid_hold0 got addr=%h req=%b exp addr=1008 req=1", imem_addr, imem_req); else passed++;
    tick();
    total++; if (imem_addr !== 64'h1008 || imem_req !== 1'b1 || id_valid !== 1'b0) $display("FAIL mid_hold1 got addr=%h req=%b v=%b exp addr=1008 req=1 v=0", imem_addr, imem_req, id_valid); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    total++; if (imem_addr !== 64'h3000 || imem_req !== 1'b1 || id_valid !== 1'b0) $display("FAIL mid_new got addr=%h req=%b v=%b exp addr=3000 req=1 v=0", imem_addr, imem_req, id_valid); else passed++;
    tick();
    total++; if (id_valid !== 1'b0 || id_instr !== 32'h2222_2222) $display("FAIL mid_discard got v=%b i=%h exp v=0 i=22222222", id_valid, id_instr); else passed++;
    // Two redirects while draining: the later target must be used.
    br_taken = 1'b1; br_target = 64'h4000;
    tick();
    br_target = 64'h5000;
    tick();
    br_taken = 1'b0; imem_ack = 1'b1;
    total++; if (imem_addr !== 64'h3000) $display("FAIL drain_hold got=%h exp=3000", imem_addr); else passed++;
    tick();
    imem_ack = 1'b0;
    total++; if (imem_addr !== 64'h5000 || imem_req !== 1'b1) $display("FAIL drain_last got addr=%h req=%b exp addr=5000 req=1", imem_addr, imem_req); else passed++;
  endtask

  task automatic test_misalign();
    br_taken = 1'b1; br_target = 64'h2002;
    tick();
    br_taken = 1'b0;
    total++; if (misalign_err !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0) $display("FAIL mis_set got err=%b req=%b v=%b exp err=1 req=0 v=0", misalign_err, imem_req, id_valid); else passed++;
    imem_ack = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (misalign_err !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0)
        $display("FAIL mis_stick%0d got err=%b req=%b v=%b exp err=1 req=0 v=0", i, misalign_err, imem_req, id_valid);
      else passed++;
    end
    imem_ack = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (misalign_err !== 1'b0 || imem_addr !== 64'h1000 || fetch_count !== 32'd0) $display("FAIL mis_clear got err=%b addr=%h cnt=%0d exp err=0 addr=1000 cnt=0", misalign_err, imem_addr, fetch_count); else passed++;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000) $display("FAIL mis_restart got req=%b addr=%h exp req=1 addr=1000", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_reset_midwait();
    imem_ack = 1'b1; imem_rdata = 32'h4444_4444; id_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    total++; if (fetch_count !== 32'd1 || imem_addr !== 64'h1004) $display("FAIL rw_pre got cnt=%0d addr=%h exp cnt=1 addr=1004", fetch_count, imem_addr); else passed++;
    tick();
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    tick();
    reset = 1'b0; imem_ack = 1'b0;
    total++; if (imem_addr !== 64'h1000 || imem_req !== 1'b0 || id_valid !== 1'b0) $display("FAIL rw_state got addr=%h req=%b v=%b exp addr=1000 req=0 v=0", imem_addr, imem_req, id_valid); else passed++;
    total++; if (fetch_count !== 32'd0 || id_pc !== 64'h0 || id_instr !== 32'h0) $display("FAIL rw_regs got cnt=%0d pc=%h i=%h exp cnt=0 pc=0 i=0", fetch_count, id_pc, id_instr); else passed++;
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    total++; if (w_addr !== 64'hFFFF_FFFF_FFFF_FFFC || w_req !== 1'b1) $display("FAIL wrap_start got addr=%h req=%b exp addr=fffffffffffffffc req=1", w_addr, w_req); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013; id_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    total++; if (w_valid !== 1'b1 || w_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || w_instr !== 32'h13) $display("FAIL wrap_valid got v=%b pc=%h i=%h exp v=1 pc=fffffffffffffffc i=00000013", w_valid, w_id_pc, w_instr); else passed++;
    tick();
    total++; if (w_addr !== 64'h0 || w_count !== 32'd1 || w_req !== 1'b1) $display("FAIL wrap_next got addr=%h cnt=%0d req=%b exp addr=0 cnt=1 req=1", w_addr, w_count, w_req); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    reset = 1'b1; imem_rdata = '0; imem_ack = 1'b0; id_ready = 1'b0;
    br_taken = 1'b0; br_target = '0;
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_valid();
    test_redirect_fetch_ack();
    test_redirect_midtxn();
    test_misalign();
    test_reset_midwait();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
